// File: rtl/me_search_ctrl.sv
// Motion-estimation sequencer: loads the current macroblock, then scans the search window row by row.
// Optional candidate-offset outputs (cand_x/cand_y) are built when ME_CAND_OUT_EN is defined.
module me_search_ctrl #(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 48,
    parameter int PIPE_LAT   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(MACRO_DIM)-1:0]  cpr_addr,
    output logic [$clog2(SEARCH_DIM)-1:0] spr_row,
    output logic [$clog2(SEARCH_DIM)-1:0] spr_col,
    output logic                          sel,
    output logic                          en_cpr,
    output logic                          en_spr,
    output logic                          valid
`ifdef ME_CAND_OUT_EN
    ,
    output logic [$clog2(SEARCH_DIM)-1:0] cand_x,
    output logic [$clog2(SEARCH_DIM)-1:0] cand_y
`endif
);

    localparam int CW     = $clog2(MACRO_DIM);
    localparam int SW     = $clog2(SEARCH_DIM);
    localparam int NPOS   = SEARCH_DIM - MACRO_DIM + 1;
    localparam int STAGES = 1 + PIPE_LAT;
    localparam int DW     = $clog2(STAGES + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SEARCH = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [CW-1:0]   cpr_q, cpr_d;
    logic [SW-1:0]   row_q, row_d;
    logic [SW-1:0]   col_q, col_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            en_cpr_q, en_cpr_d;
    logic            en_spr_q, en_spr_d;
    logic [STAGES:1] vld_q, vld_d;
    logic [STAGES:0] vld_pipe;
    logic            cand_flag;

    always_comb begin
        state_d = state_q;
        cpr_d   = cpr_q;
        row_d   = row_q;
        col_d   = col_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cpr_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_LOAD: begin
                if (cpr_q == CW'(MACRO_DIM - 1)) state_d = S_SEARCH;
                else                             cpr_d   = cpr_q + CW'(1);
            end
            S_SEARCH: begin
                // The last row of the last slice holds its address through drain.
                if (row_q == SW'(SEARCH_DIM - 1)) begin
                    if (col_q == SW'(NPOS - 1)) begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end else begin
                        row_d = '0;
                        col_d = col_q + SW'(1);
                    end
                end else begin
                    row_d = row_q + SW'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == DW'(STAGES - 1)) state_d = S_DONE;
                else                            drain_d = drain_q + DW'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A candidate exists once the slice holds a full macroblock height of rows.
    assign cand_flag = (state_q == S_SEARCH) && (row_q >= SW'(MACRO_DIM - 1));
    assign vld_pipe  = {vld_q, cand_flag};

    always_comb begin
        en_cpr_d = (state_q == S_LOAD);
        en_spr_d = (state_q == S_SEARCH);
        vld_d    = vld_pipe[STAGES-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cpr_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            drain_q  <= '0;
            en_cpr_q <= 1'b0;
            en_spr_q <= 1'b0;
            vld_q    <= '0;
        end else begin
            state_q  <= state_d;
            cpr_q    <= cpr_d;
            row_q    <= row_d;
            col_q    <= col_d;
            drain_q  <= drain_d;
            en_cpr_q <= en_cpr_d;
            en_spr_q <= en_spr_d;
            vld_q    <= vld_d;
        end
    end

`ifdef ME_CAND_OUT_EN
    logic [STAGES:1][SW-1:0] cx_q, cx_d, cy_q, cy_d;
    logic [STAGES:0][SW-1:0] cx_pipe, cy_pipe;
    logic [SW-1:0]           cand_y_now;

    assign cand_y_now = row_q - SW'(MACRO_DIM - 1);
    assign cx_pipe    = {cx_q, col_q};
    assign cy_pipe    = {cy_q, cand_y_now};

    // Inner stages shift freely; the output stage only captures qualified offsets.
    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        for (int i = 1; i <= STAGES; i++) begin
            if (i < STAGES || vld_pipe[STAGES-1]) begin
                cx_d[i] = cx_pipe[i-1];
                cy_d[i] = cy_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

    assign cand_x = cx_q[STAGES];
    assign cand_y = cy_q[STAGES];
`endif

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign sel      = (state_q == S_SEARCH) || (state_q == S_DRAIN);
    assign en_cpr   = en_cpr_q;
    assign en_spr   = en_spr_q;
    assign valid    = vld_q[STAGES];
    assign cpr_addr = cpr_q;
    assign spr_row  = row_q;
    assign spr_col  = col_q;

endmodule

// File: tb/tb_me_search_ctrl.sv
// Bench for me_search_ctrl: per-cycle comparison against a timing model built from cycle-number arithmetic.
module tb_me_search_ctrl;

    localparam int MD      = 16;
    localparam int SD      = 48;
    localparam int PL      = 2;
    localparam int NP      = SD - MD + 1;
    localparam int LAT     = 1 + PL;
    localparam int T_SRCH  = 1 + MD;             // first SEARCH cycle (17)
    localparam int T_DRAIN = T_SRCH + NP * SD;   // first DRAIN cycle (1601)
    localparam int T_DONE  = T_DRAIN + LAT;      // done cycle (1604)

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, sel, en_cpr, en_spr, valid;
    logic [3:0] cpr_addr;
    logic [5:0] spr_row, spr_col;
`ifdef ME_CAND_OUT_EN
    logic [5:0] cand_x, cand_y;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_done   = 0;

    always #5 clk = ~clk;

    me_search_ctrl #(.MACRO_DIM(MD), .SEARCH_DIM(SD), .PIPE_LAT(PL)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .cpr_addr (cpr_addr),
        .spr_row  (spr_row),
        .spr_col  (spr_col),
        .sel      (sel),
        .en_cpr   (en_cpr),
        .en_spr   (en_spr),
        .valid    (valid)
`ifdef ME_CAND_OUT_EN
        ,
        .cand_x   (cand_x),
        .cand_y   (cand_y)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [21:0] obs();
        return {busy, done, sel, en_cpr, en_spr, valid, cpr_addr, spr_row, spr_col};
    endfunction

    // Expected outputs on cycle k of a scan, straight from the timing rules.
    function automatic logic [21:0] exp_at(int k);
        logic b, d, s, ec, es, v;
        int ca, row, col, j;
        b  = (k >= 1) && (k <= T_DONE);
        d  = (k == T_DONE);
        s  = (k >= T_SRCH) && (k < T_DONE);
        ec = (k >= 2) && (k <= T_SRCH);
        es = (k > T_SRCH) && (k <= T_DRAIN);
        ca = (k <= MD) ? k - 1 : MD - 1;
        if (k < T_SRCH) begin
            row = 0; col = 0;
        end else if (k < T_DRAIN) begin
            row = (k - T_SRCH) % SD; col = (k - T_SRCH) / SD;
        end else begin
            row = SD - 1; col = NP - 1;
        end
        j = k - LAT;
        v = (j >= T_SRCH) && (j < T_DRAIN) && (((j - T_SRCH) % SD) >= MD - 1);
        return {b, d, s, ec, es, v, 4'(ca), 6'(row), 6'(col)};
    endfunction

    // One scan from an idle cycle; optional ignored starts and an early stop at abort_at.
    task automatic run_scan(input int extra_a, input int extra_b, input int n_rand, input int abort_at);
        int rk[8];
        int nv;
        logic hit;
        logic [21:0] e, o;
        for (int i = 0; i < 8; i++) rk[i] = (i < n_rand) ? int'($urandom_range(T_DONE, 1)) : -1;
        nv = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= T_DONE + 1; k++) begin
            hit = (k == extra_a) || (k == extra_b);
            foreach (rk[i]) if (rk[i] == k) hit = 1'b1;
            start = hit;
            e = exp_at(k);
            o = obs();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL scan_cycle k=%0d got=%h exp=%h", k, o, e);
            end
            if (valid === 1'b1) nv++;
`ifdef ME_CAND_OUT_EN
            if (nv > 0) begin
                vectors++;
                if (cand_x !== 6'((nv - 1) / NP) || cand_y !== 6'((nv - 1) % NP)) begin
                    miscompares++;
                    $display("FAIL cand k=%0d got=(%0d,%0d) exp=(%0d,%0d)", k, cand_x, cand_y,
                             (nv - 1) / NP, (nv - 1) % NP);
                end
            end
`endif
            if (done === 1'b1) last_done = cyc;
            if (k == abort_at) begin
                start = 1'b0;
                return;
            end
            if (k <= T_DONE) tick();
        end
        start = 1'b0;
        vectors++;
        if (nv !== NP * NP) begin
            miscompares++;
            $display("FAIL valid_count got=%0d exp=%0d", nv, NP * NP);
        end
    endtask

    task automatic check_zero(input string tag);
        vectors++;
        if (obs() !== 22'd0) begin
            miscompares++;
            $display("FAIL %s got=%h exp=0", tag, obs());
        end
`ifdef ME_CAND_OUT_EN
        vectors++;
        if (cand_x !== 6'd0 || cand_y !== 6'd0) begin
            miscompares++;
            $display("FAIL %s_cand got=(%0d,%0d) exp=(0,0)", tag, cand_x, cand_y);
        end
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) tick();
        check_zero("reset_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_zero("post_reset_idle");
        end
    endtask

    task automatic test_single_scan();
        run_scan(0, 0, 0, 0);
    endtask

    task automatic test_start_while_busy();
        repeat ($urandom_range(4, 0)) tick();
        run_scan(5, T_DONE, 8, 0);
    endtask

    task automatic test_back_to_back();
        int base;
        base = cyc;
        run_scan(0, 0, 0, 0);
        run_scan(0, 0, 0, 0);
        vectors++;
        if (last_done - base !== 2 * T_DONE + 1) begin
            miscompares++;
            $display("FAIL b2b_done_cycle got=%0d exp=%0d", last_done - base, 2 * T_DONE + 1);
        end
    endtask

    task automatic test_mid_reset();
        int stops[2];
        stops[0] = 500;
        stops[1] = int'($urandom_range(T_DONE, 20));
        foreach (stops[s]) begin
            repeat ($urandom_range(3, 0)) tick();
            run_scan(0, 0, 0, stops[s]);
            rst_n = 1'b0;
            #1;
            check_zero("mid_reset_async");
            repeat (3) begin
                tick();
                check_zero("mid_reset_hold");
            end
            rst_n = 1'b1;
            tick();
            check_zero("mid_reset_release");
            run_scan(0, 0, 0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_single_scan();
        test_start_while_busy();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
